mcp9808_scheduler: RTL and testbench

Sequencing controller that sits between host logic and the `mcp9808` I2C interface block. It runs periodic ambient-temperature polls and arbitrates them against host configuration requests: resolution change, T_LOWER/T_UPPER/T_CRIT writes, and shutdown/wake. It issues exactly one transaction at a time to the interface. It also keeps shadow copies of the alert bounds, so it can produce local alarm flags from each new reading.

---
 rtl/mcp9808_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_mcp9808_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp9808_scheduler.sv
// Transaction sequencer in front of the mcp9808 I2C block: periodic temperature polls,
// host bound/resolution writes and shutdown/wake, one transaction at a time, with local alarms.
module mcp9808_scheduler #(
  parameter int POLL_PERIOD = 1_000_000,
  parameter int CMD_TIMEOUT = 65_535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        poll_en,
  input  logic        sleep_req,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [10:0] req_data,
  input  logic        err_clr,
  input  logic        if_ready,
  input  logic [10:0] if_T_o,
  output logic        if_update,
  output logic [1:0]  if_T_write,
  output logic [10:0] if_T_i,
  output logic [1:0]  if_res,
  output logic        if_shutdown,
  output logic [10:0] temp,
  output logic        temp_valid,
  output logic        alarm_lo,
  output logic        alarm_hi,
  output logic        alarm_crit,
  output logic        sleeping,
  output logic        err_timeout,
  output logic [1:0]  state_dbg
);
  // Host handshake: a request transfers on a clock edge where req_valid && req_ready.
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_SLEEP = 2'd3;
  localparam logic [2:0] K_READ = 3'd0, K_BOUND = 3'd1, K_RES = 3'd2,
                         K_SHDN_ON = 3'd3, K_SHDN_OFF = 3'd4;
  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(CMD_TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    kind_q, kind_d;
  logic [1:0]    op_q, op_d;
  logic [10:0]   data_q, data_d;
  logic          noop_q, noop_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic          poll_pending_q, poll_pending_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          if_update_q, if_update_d;
  logic [1:0]    if_t_write_q, if_t_write_d;
  logic [10:0]   if_t_i_q, if_t_i_d;
  logic [1:0]    if_res_q, if_res_d;
  logic          if_shutdown_q, if_shutdown_d;
  logic [10:0]   temp_q, temp_d;
  logic          temp_valid_q, temp_valid_d;
  logic          alarm_lo_q, alarm_lo_d, alarm_hi_q, alarm_hi_d, alarm_crit_q, alarm_crit_d;
  logic          sleeping_q, sleeping_d;
  logic          err_timeout_q, err_timeout_d;
  logic [10:0]   t_lower_q, t_lower_d, t_upper_q, t_upper_d, t_crit_q, t_crit_d;
  logic          wrap, poll_clr, timeout;

  assign req_ready = (state_q == S_IDLE) && !sleep_req && !sleeping_q;

  always_comb begin
    state_d = state_q;  kind_d = kind_q;  op_d = op_q;  data_d = data_q;  noop_d = noop_q;
    poll_cnt_d = '0;  wrap = 1'b0;  poll_clr = 1'b0;  timeout = 1'b0;
    to_cnt_d = to_cnt_q + TW'(1);
    if_update_d = if_update_q;  if_t_write_d = if_t_write_q;  if_t_i_d = if_t_i_q;
    if_res_d = if_res_q;  if_shutdown_d = if_shutdown_q;
    temp_d = temp_q;  temp_valid_d = 1'b0;
    alarm_lo_d = alarm_lo_q;  alarm_hi_d = alarm_hi_q;  alarm_crit_d = alarm_crit_q;
    sleeping_d = sleeping_q;  err_timeout_d = err_timeout_q & ~err_clr;
    t_lower_d = t_lower_q;  t_upper_d = t_upper_q;  t_crit_d = t_crit_q;

    if (poll_en && !sleeping_q) begin
      if (poll_cnt_q == POLL_LAST) wrap = 1'b1;
      else poll_cnt_d = poll_cnt_q + PW'(1);
    end

    if (temp_valid_q) begin
      alarm_crit_d = $signed(temp_q) >= $signed(t_crit_q);
      alarm_hi_d   = $signed(temp_q) >  $signed(t_upper_q);
      alarm_lo_d   = $signed(temp_q) <  $signed(t_lower_q);
    end

    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (sleep_req && !sleeping_q) begin
          state_d = S_ISSUE;  kind_d = K_SHDN_ON;  if_shutdown_d = 1'b1;
        end else if (req_valid && req_ready) begin
          state_d = S_ISSUE;  op_d = req_op;  data_d = req_data;
          if (req_op == 2'b00) begin
            kind_d = K_RES;
            noop_d = (req_data[1:0] == if_res_q);
            if_res_d = req_data[1:0];
          end else begin
            kind_d = K_BOUND;  if_t_write_d = req_op;  if_t_i_d = req_data;
          end
        end else if (poll_pending_q) begin
          state_d = S_ISSUE;  kind_d = K_READ;  if_update_d = 1'b1;  poll_clr = 1'b1;
        end
      end
      S_ISSUE: begin
        // An unchanged resolution gives the interface nothing to do.
        if (kind_q == K_RES && noop_q) begin
          state_d = S_IDLE;
        end else if (!if_ready) begin
          state_d = S_WAIT;  to_cnt_d = '0;
          if_update_d = 1'b0;  if_t_write_d = 2'b00;  if_t_i_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          timeout = 1'b1;
        end
      end
      S_WAIT: begin
        if (if_ready) begin
          state_d = S_IDLE;
          case (kind_q)
            K_READ:     begin temp_d = if_T_o;  temp_valid_d = 1'b1; end
            K_BOUND: begin
              if (op_q == 2'b01) t_lower_d = data_q;
              if (op_q == 2'b10) t_upper_d = data_q;
              if (op_q == 2'b11) t_crit_d  = data_q;
            end
            K_SHDN_ON:  begin state_d = S_SLEEP;  sleeping_d = 1'b1; end
            K_SHDN_OFF: sleeping_d = 1'b0;
            default: ;
          endcase
        end else if (to_cnt_q == TO_LAST) begin
          timeout = 1'b1;
        end
      end
      default: begin
        to_cnt_d = '0;
        if (!sleep_req) begin
          if_shutdown_d = 1'b0;  kind_d = K_SHDN_OFF;  state_d = S_WAIT;
        end
      end
    endcase

    // An aborted shutdown entry leaves the sensor awake; an aborted wake has already released it.
    if (timeout) begin
      state_d = S_IDLE;  err_timeout_d = 1'b1;
      if_update_d = 1'b0;  if_t_write_d = 2'b00;  if_t_i_d = '0;
      if (kind_q == K_SHDN_ON) if_shutdown_d = 1'b0;
      if (kind_q == K_SHDN_OFF) sleeping_d = 1'b0;
    end

    poll_pending_d = wrap | (poll_pending_q & ~poll_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  kind_q <= K_READ;  op_q <= 2'b00;  data_q <= '0;  noop_q <= 1'b0;
      poll_cnt_q <= '0;  poll_pending_q <= 1'b0;  to_cnt_q <= '0;
      if_update_q <= 1'b0;  if_t_write_q <= 2'b00;  if_t_i_q <= '0;
      if_res_q <= 2'b11;  if_shutdown_q <= 1'b0;
      temp_q <= '0;  temp_valid_q <= 1'b0;
      alarm_lo_q <= 1'b0;  alarm_hi_q <= 1'b0;  alarm_crit_q <= 1'b0;
      sleeping_q <= 1'b0;  err_timeout_q <= 1'b0;
      t_lower_q <= 11'h400;  t_upper_q <= 11'h3FF;  t_crit_q <= 11'h3FF;
    end else begin
      state_q <= state_d;  kind_q <= kind_d;  op_q <= op_d;  data_q <= data_d;  noop_q <= noop_d;
      poll_cnt_q <= poll_cnt_d;  poll_pending_q <= poll_pending_d;  to_cnt_q <= to_cnt_d;
      if_update_q <= if_update_d;  if_t_write_q <= if_t_write_d;  if_t_i_q <= if_t_i_d;
      if_res_q <= if_res_d;  if_shutdown_q <= if_shutdown_d;
      temp_q <= temp_d;  temp_valid_q <= temp_valid_d;
      alarm_lo_q <= alarm_lo_d;  alarm_hi_q <= alarm_hi_d;  alarm_crit_q <= alarm_crit_d;
      sleeping_q <= sleeping_d;  err_timeout_q <= err_timeout_d;
      t_lower_q <= t_lower_d;  t_upper_q <= t_upper_d;  t_crit_q <= t_crit_d;
    end
  end

  assign if_update   = if_update_q;
  assign if_T_write  = if_t_write_q;
  assign if_T_i      = if_t_i_q;
  assign if_res      = if_res_q;
  assign if_shutdown = if_shutdown_q;
  assign temp        = temp_q;
  assign temp_valid  = temp_valid_q;
  assign alarm_lo    = alarm_lo_q;
  assign alarm_hi    = alarm_hi_q;
  assign alarm_crit  = alarm_crit_q;
  assign sleeping    = sleeping_q;
  assign err_timeout = err_timeout_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_mcp9808_scheduler.sv
// Directed + randomized bench for mcp9808_scheduler; the interface side is played by tasks
// and expected temperatures/alarms come from a signed-arithmetic model of the alert bounds.
module tb_mcp9808_scheduler;
  localparam int POLL = 100;
  localparam int CMD_TO = 150;

  logic        clk = 1'b0, rst = 1'b1;
  logic        poll_en = 1'b0, sleep_req = 1'b0, req_valid = 1'b0, err_clr = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [10:0] req_data = '0;
  logic        if_ready = 1'b1;
  logic [10:0] if_T_o = '0;
  logic        req_ready, if_update, if_shutdown, temp_valid;
  logic        alarm_lo, alarm_hi, alarm_crit, sleeping, err_timeout;
  logic [1:0]  if_T_write, if_res, state_dbg;
  logic [10:0] if_T_i, temp;

  mcp9808_scheduler #(.POLL_PERIOD(POLL), .CMD_TIMEOUT(CMD_TO)) dut (
    .clk(clk), .rst(rst), .poll_en(poll_en), .sleep_req(sleep_req),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .err_clr(err_clr), .if_ready(if_ready), .if_T_o(if_T_o), .if_update(if_update),
    .if_T_write(if_T_write), .if_T_i(if_T_i), .if_res(if_res), .if_shutdown(if_shutdown),
    .temp(temp), .temp_valid(temp_valid), .alarm_lo(alarm_lo), .alarm_hi(alarm_hi),
    .alarm_crit(alarm_crit), .sleeping(sleeping), .err_timeout(err_timeout),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int tests_run = 0, fails = 0, cyc = 0;
  logic [10:0] exp_q[$];
  logic [10:0] bnd [4];

  function automatic int sx(input logic [10:0] v);
    int r;
    r = int'(v);
    if (v[10]) r -= 2048;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: all driving and sampling happens at the falling edge
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic serve(input int busy, input logic [10:0] rd);
    if_ready = 1'b0;
    tick();
    check("strobe_dropped", {if_update, if_T_write}, 3'b000);
    repeat (busy - 1) tick();
    if_T_o = rd;
    if_ready = 1'b1;
    tick();
  endtask

  task automatic wait_update(input int max_cyc);
    int n = 0;
    while (!if_update && n < max_cyc) begin
      tick();
      n++;
    end
    check("upd_seen", if_update, 1'b1);
  endtask

  task automatic host_req(input logic [1:0] op, input logic [10:0] val);
    int n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1;  req_op = op;  req_data = val;
    tick();
    req_valid = 1'b0;
    check("accept_state", state_dbg, 2'd1);
    if (op != 2'b00) begin
      check("bound_sel", if_T_write, op);
      check("bound_val", if_T_i, val);
    end
  endtask

  task automatic bound_write(input logic [1:0] op, input logic [10:0] val, input int busy);
    host_req(op, val);
    serve(busy, 11'h000);
    bnd[op] = val;
    check("bound_done", state_dbg, 2'd0);
  endtask

  task automatic read_txn(input int busy, input logic [10:0] rd);
    logic [10:0] exp_t;
    exp_q.push_back(rd);
    check("upd_strobe", if_update, 1'b1);
    serve(busy, rd);
    exp_t = exp_q.pop_front();
    check("temp_valid_pulse", temp_valid, 1'b1);
    check("temp", temp, exp_t);
    tick();
    check("temp_valid_low", temp_valid, 1'b0);
    check("alarm_crit", alarm_crit, sx(exp_t) >= sx(bnd[3]));
    check("alarm_hi", alarm_hi, sx(exp_t) > sx(bnd[2]));
    check("alarm_lo", alarm_lo, sx(exp_t) < sx(bnd[1]));
  endtask

  task automatic one_poll(input int busy, input logic [10:0] rd);
    poll_en = 1'b1;
    wait_update(POLL + 10);
    poll_en = 1'b0;
    read_txn(busy, rd);
  endtask

  initial begin
    int last_upd, k, no_upd;
    logic [1:0] op;
    logic [10:0] val, rd;
    bnd[0] = 11'h000;  bnd[1] = 11'h400;  bnd[2] = 11'h3FF;  bnd[3] = 11'h3FF;

    // reset
    repeat (3) tick();
    rst = 1'b0;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_state", state_dbg, 2'd0);
    check("rst_res", if_res, 2'b11);
    check("rst_strobes", {if_update, if_T_write, if_T_i, if_shutdown}, 15'd0);
    check("rst_flags", {temp, temp_valid, alarm_lo, alarm_hi, alarm_crit, sleeping, err_timeout}, 17'd0);

    // periodic polls, 20-cycle busy interface returning +100 C
    poll_en = 1'b1;
    wait_update(POLL + 10);
    last_upd = cyc;
    read_txn(20, 11'h190);
    for (int i = 0; i < 2; i++) begin
      wait_update(POLL + 10);
      check("poll_interval", cyc - last_upd, POLL);
      last_upd = cyc;
      read_txn(20, 11'h190);
    end
    poll_en = 1'b0;
    tick();

    // T_UPPER write then a reading above it
    bound_write(2'b10, 11'h140, 3);
    one_poll(6, 11'h150);

    // resolution change, then the same value again completes without the interface
    host_req(2'b00, 11'h001);
    check("res_applied", if_res, 2'b01);
    serve(5, 11'h000);
    check("res_done", req_ready, 1'b1);
    host_req(2'b00, 11'h001);
    tick();
    check("res_noop_ready", req_ready, 1'b1);
    check("res_noop_hold", if_res, 2'b01);

    // randomized bound writes and readings near or away from the bounds
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(1, 3));
      val = 11'($urandom_range(0, 2047));
      bound_write(op, val, $urandom_range(1, 8));
      k = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) rd = bnd[k] + 11'($urandom_range(0, 2)) - 11'd1;
      else rd = 11'($urandom_range(0, 2047));
      one_poll($urandom_range(1, 25), rd);
    end

    // interface never goes busy: abort after the timeout, bound not committed
    host_req(2'b11, 11'h010);
    repeat (CMD_TO - 1) tick();
    check("to_still_issue", {state_dbg, if_T_write}, {2'd1, 2'b11});
    check("to_err_before", err_timeout, 1'b0);
    tick();
    check("to_idle", state_dbg, 2'd0);
    check("to_strobe_drop", if_T_write, 2'b00);
    check("to_err_set", err_timeout, 1'b1);
    tick();
    check("to_err_sticky", err_timeout, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_err_clr", err_timeout, 1'b0);
    one_poll(4, 11'h100);

    // shutdown beats a poll that went pending while a long write was in flight
    poll_en = 1'b1;
    host_req(2'b01, 11'h7F0);
    if_ready = 1'b0;
    repeat (POLL + 10) tick();
    sleep_req = 1'b1;
    if_ready = 1'b1;
    tick();
    bnd[1] = 11'h7F0;
    check("sd_idle", {state_dbg, if_shutdown}, {2'd0, 1'b0});
    tick();
    check("sd_first", {if_shutdown, if_update}, 2'b10);
    serve(5, 11'h000);
    check("sd_sleeping", {state_dbg, sleeping}, {2'd3, 1'b1});
    no_upd = 0;
    for (int i = 0; i < POLL + 50; i++) begin
      tick();
      if (if_update) no_upd++;
    end
    check("sd_no_poll", no_upd, 0);
    check("sd_blocked", req_ready, 1'b0);
    poll_en = 1'b0;
    sleep_req = 1'b0;
    tick();
    check("wake_release", {state_dbg, if_shutdown, sleeping}, {2'd2, 1'b0, 1'b1});
    serve(4, 11'h000);
    check("wake_done", {state_dbg, sleeping}, {2'd0, 1'b0});
    tick();
    read_txn(3, 11'h6A0);

    // asynchronous reset in the middle of a read
    one_poll(2, 11'h0C8);
    poll_en = 1'b1;
    wait_update(POLL + 10);
    poll_en = 1'b0;
    if_ready = 1'b0;
    repeat (3) tick();
    check("mid_wait", state_dbg, 2'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_state", {state_dbg, req_ready}, {2'd0, 1'b1});
    check("arst_res", if_res, 2'b11);
    check("arst_strobes", {if_update, if_T_write, if_T_i, if_shutdown}, 15'd0);
    check("arst_flags", {temp, temp_valid, alarm_lo, alarm_hi, alarm_crit, sleeping, err_timeout}, 17'd0);
    if_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_temp", temp, 11'h000);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
